pstats_event_counter: RTL and testbench
=======================================

PSTATS_EVENT_COUNTER -- requirements
Module: pstats_event_counter

Interface
REQ-001 The block SHALL have parameter g_trig_width, default 10, the number of per-port event trigger inputs.
REQ-002 The block SHALL have parameter g_cnt_width, default 32, the width of each event counter.
REQ-003 The block SHALL have parameter g_addr_width, default 4, the read address width; 2**g_addr_width >= g_trig_width.
REQ-004 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 trig_i  input  g_trig_width  per-port event triggers; bit n rising edge = one event on port n.
REQ-007 clr_all_i  input  1  synchronous clear of all counters and overflow flags.
REQ-008 rd_req_i  input  1  read request strobe; accepted only when busy_o is low.
REQ-009 rd_addr_i  input  g_addr_width  port index to read; sampled with an accepted rd_req_i.
REQ-010 rd_clr_i  input  1  read-and-clear qualifier; sampled with an accepted rd_req_i.
REQ-011 busy_o  output  1  high while a read is in progress.
REQ-012 rd_valid_o  output  1  one-cycle strobe; rd_data_o and rd_err_o are valid while it is high.
REQ-013 rd_data_o  output  g_cnt_width  captured counter value.
REQ-014 rd_err_o  output  1  address out of range (rd_addr_i >= g_trig_width).
REQ-015 ovf_o  output  g_trig_width  sticky per-port counter wrap flags.

Function
REQ-016 Edge detect: trig_i SHALL be registered into trig_d; event[n] = trig_i[n] & ~trig_d[n]. Pulses of any width count once. A trigger held high counts once.
REQ-017 An event detected at edge k SHALL appear in cnt[n] after edge k (zero latency beyond the sampling edge).
REQ-018 Counters SHALL wrap from all-ones to 0, modulo 2**g_cnt_width. The wrapping edge SHALL set ovf_o[n], which stays set until it is cleared.
REQ-019 Read FSM states SHALL be IDLE, READ and RESP. busy_o = (state != IDLE).
REQ-020 IDLE: when rd_req_i is high at edge k, the FSM SHALL latch rd_addr_i and rd_clr_i and go to READ. rd_req_i is ignored in READ and RESP, with no queueing.
REQ-021 READ at edge k+1 SHALL do all of the following:
  - rd_data_o <= cnt[addr], the value before edge k+1, which includes events up to edge k;
  - rd_err_o <= (addr >= g_trig_width);
  - rd_valid_o <= 1;
  - go to RESP.
REQ-022 RESP at edge k+2 SHALL set rd_valid_o <= 0 and go to IDLE. rd_valid_o is therefore high for exactly one cycle, and the next request is accepted at edge k+3 at the earliest.
REQ-023 For an out-of-range address, rd_data_o SHALL be 0 and no counter or flag SHALL change.
REQ-024 Read-and-clear at edge k+1 SHALL set cnt[addr] <= (event[addr] ? 1 : 0) and clear ovf_o[addr]. An event on the same edge is therefore never lost. A wrap on that edge is superseded by the clear.
REQ-025 A non-clearing read SHALL not disturb counting. An event at edge k+1 increments cnt[addr] but is excluded from rd_data_o.
REQ-026 clr_all_i SHALL set all counters and ovf_o to 0, and it dominates same-edge events, which are lost. It SHALL not affect the FSM. A capture on the same edge returns the pre-clear value.
REQ-027 rd_data_o and rd_err_o SHALL hold their values until the next capture.

Reset
REQ-028 rst_i high at a clock edge SHALL set all of the following, overriding all other activity:
  - every counter, ovf_o, trig_d, rd_data_o, rd_err_o, rd_valid_o and the latched address/clear to 0;
  - state to IDLE.
REQ-029 After a reset asserted mid-read, rd_valid_o SHALL stay low. A trig_i bit held high through reset release SHALL not count until it falls and rises again.

Verification
REQ-030 Port 3 gets 5 one-cycle pulses 20 cycles apart, then a read of addr 3 with rd_clr_i=0 -> rd_valid_o high 1 cycle, one cycle after acceptance, with rd_data_o=5; a re-read returns 5.
REQ-031 Read-and-clear of addr 3 with a port-3 rising edge on the capture edge (k+1) -> rd_data_o excludes that event; a subsequent read returns 1.
REQ-032 With g_cnt_width=4, 17 events on port 0 -> ovf_o[0]=1 and the read returns 1; a read-and-clear leaves ovf_o[0]=0 and a further read returns 0.
REQ-033 A read of addr 12 with g_trig_width=10 -> rd_err_o=1, rd_data_o=0, and no counter change.
REQ-034 A back-to-back rd_req_i on edges k, k+1 and k+2 -> only the edge-k request is served; a request at k+3 is accepted, and busy_o is high for exactly 2 cycles per read.
REQ-035 rst_i pulsed during READ while trig_i[2] is held high -> no rd_valid_o, all counts 0, and port 2 stays at 0 until a new rising edge.

Source files
------------

// File: rtl/pstats_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : pstats_event_counter
// Function : Per-port rising-edge event counters with sticky wrap flags and a
//            three-state read port supporting read-and-clear.
// Revision : 1.0 - initial release
// ============================================================================

module pstats_event_counter #(
    parameter int g_trig_width = 10,
    parameter int g_cnt_width  = 32,
    parameter int g_addr_width = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [g_trig_width-1:0] trig_i,
    input  logic                    clr_all_i,
    input  logic                    rd_req_i,
    input  logic [g_addr_width-1:0] rd_addr_i,
    input  logic                    rd_clr_i,
    output logic                    busy_o,
    output logic                    rd_valid_o,
    output logic [g_cnt_width-1:0]  rd_data_o,
    output logic                    rd_err_o,
    output logic [g_trig_width-1:0] ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [g_trig_width-1:0] r_trig_d;
    logic [g_trig_width-1:0] r_hold;
    logic [g_trig_width-1:0] r_ovf;
    logic [g_cnt_width-1:0]  r_cnt [g_trig_width];
    logic [g_addr_width-1:0] r_addr;
    logic                    r_clr;
    logic                    r_rd_valid;
    logic [g_cnt_width-1:0]  r_rd_data;
    logic                    r_rd_err;

    logic [g_trig_width-1:0] w_event;
    logic [g_trig_width-1:0] w_rc_hit;
    logic [g_cnt_width-1:0]  w_rd_cnt;
    logic                    w_addr_err;

    // r_hold masks inputs that were already high while reset was applied, so a
    // level held through reset release is not mistaken for a fresh edge.
    assign w_event    = trig_i & ~r_trig_d & ~r_hold;
    assign w_addr_err = (32'(r_addr) >= 32'(g_trig_width));

    always_comb begin
        w_rd_cnt = '0;
        w_rc_hit = '0;
        for (int n = 0; n < g_trig_width; n++) begin
            if (32'(r_addr) == 32'(n)) begin
                w_rd_cnt    = r_cnt[n];
                w_rc_hit[n] = (r_state == ST_READ) && r_clr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_trig_d <= '0;
            r_hold   <= trig_i;
        end else begin
            r_trig_d <= trig_i;
            r_hold   <= '0;
        end
    end

    // Priority: reset, global clear, read-and-clear (keeps a same-edge event),
    // then ordinary counting.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < g_trig_width; n++) begin
            if (rst_i || clr_all_i) begin
                r_cnt[n] <= '0;
                r_ovf[n] <= 1'b0;
            end else if (w_rc_hit[n]) begin
                r_cnt[n] <= {{(g_cnt_width-1){1'b0}}, w_event[n]};
                r_ovf[n] <= 1'b0;
            end else if (w_event[n]) begin
                r_cnt[n] <= r_cnt[n] + g_cnt_width'(1);
                if (&r_cnt[n]) begin
                    r_ovf[n] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_clr      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rd_req_i) begin
                        r_addr  <= rd_addr_i;
                        r_clr   <= rd_clr_i;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rd_data  <= w_addr_err ? '0 : w_rd_cnt;
                    r_rd_err   <= w_addr_err;
                    r_rd_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = (r_state != ST_IDLE);
    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;
    assign rd_err_o   = r_rd_err;
    assign ovf_o      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pstats_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pstats_event_counter
// Function : Directed self-checking bench for pstats_event_counter (4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================

module tb_pstats_event_counter;

    localparam int c_tw = 10;
    localparam int c_cw = 4;
    localparam int c_aw = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_tw-1:0] trig = '0;
    logic            clr_all = 1'b0;
    logic            rd_req = 1'b0;
    logic [c_aw-1:0] rd_addr = '0;
    logic            rd_clr = 1'b0;
    logic            busy;
    logic            rd_valid;
    logic [c_cw-1:0] rd_data;
    logic            rd_err;
    logic [c_tw-1:0] ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [c_cw-1:0] d;
    logic            e;

    pstats_event_counter #(
        .g_trig_width (c_tw),
        .g_cnt_width  (c_cw),
        .g_addr_width (c_aw)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .trig_i     (trig),
        .clr_all_i  (clr_all),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_clr_i   (rd_clr),
        .busy_o     (busy),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_err_o   (rd_err),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int port);
        trig[port] = 1'b1;
        step(1);
        trig[port] = 1'b0;
        step(1);
    endtask

    // Full read transaction; cap_mask / cap_clr_all are applied on the capture edge.
    task automatic do_read(input logic [c_aw-1:0] addr, input logic clr,
                           input logic [c_tw-1:0] cap_mask, input logic cap_clr_all,
                           output logic [c_cw-1:0] data, output logic err);
        rd_req  = 1'b1;
        rd_addr = addr;
        rd_clr  = clr;
        step(1);
        rd_req  = 1'b0;
        rd_clr  = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("valid_low_in_read", 32'(rd_valid), 32'd0);
        trig    = trig | cap_mask;
        clr_all = cap_clr_all;
        step(1);
        trig    = trig & ~cap_mask;
        clr_all = 1'b0;
        chk("valid_high_resp", 32'(rd_valid), 32'd1);
        data = rd_data;
        err  = rd_err;
        step(1);
        chk("valid_one_cycle", 32'(rd_valid), 32'd0);
        chk("busy_two_cycles", 32'(busy), 32'd0);
        chk("data_held", 32'(rd_data), 32'(data));
    endtask

    initial begin
        // Reset state
        step(2);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Five spaced pulses on port 3, read twice without clear
        for (int i = 0; i < 5; i++) begin
            pulse(3);
            step(18);
        end
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("p3_read5", 32'(d), 32'd5);
        chk("p3_err0", 32'(e), 32'd0);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("p3_reread5", 32'(d), 32'd5);

        // Read-and-clear with an event on the capture edge
        do_read(4'd3, 1'b1, 10'h008, 1'b0, d, e);
        chk("p3_rc_data", 32'(d), 32'd5);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("p3_after_rc", 32'(d), 32'd1);

        // Plain read with capture-edge event: excluded from data, still counted
        do_read(4'd3, 1'b0, 10'h008, 1'b0, d, e);
        chk("p3_nc_excl", 32'(d), 32'd1);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("p3_nc_counted", 32'(d), 32'd2);

        // 17 events on 4-bit port 0: wrap sets ovf, count 1
        for (int i = 0; i < 17; i++) pulse(0);
        chk("p0_ovf_set", 32'(ovf), 32'h001);
        do_read(4'd0, 1'b0, '0, 1'b0, d, e);
        chk("p0_wrap_data", 32'(d), 32'd1);
        chk("p0_ovf_sticky", 32'(ovf), 32'h001);
        do_read(4'd0, 1'b1, '0, 1'b0, d, e);
        chk("p0_rc_data", 32'(d), 32'd1);
        chk("p0_ovf_cleared", 32'(ovf), 32'h000);
        do_read(4'd0, 1'b0, '0, 1'b0, d, e);
        chk("p0_after_rc", 32'(d), 32'd0);

        // Out-of-range address
        do_read(4'd12, 1'b1, '0, 1'b0, d, e);
        chk("oor_err", 32'(e), 32'd1);
        chk("oor_data", 32'(d), 32'd0);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("oor_p3_intact", 32'(d), 32'd2);
        chk("oor_err_clear", 32'(e), 32'd0);

        // Back-to-back requests: only first and the k+3 one are served
        pulse(4);
        pulse(4);
        rd_req  = 1'b1;
        rd_addr = 4'd3;
        step(1);
        chk("b2b_busy_k", 32'(busy), 32'd1);
        rd_addr = 4'd4;
        rd_clr  = 1'b1;
        step(1);
        chk("b2b_valid_k1", 32'(rd_valid), 32'd1);
        chk("b2b_data_k1", 32'(rd_data), 32'd2);
        chk("b2b_busy_k1", 32'(busy), 32'd1);
        rd_clr  = 1'b0;
        step(1);
        chk("b2b_busy_k2", 32'(busy), 32'd0);
        step(1);
        rd_req = 1'b0;
        chk("b2b_accept_k3", 32'(busy), 32'd1);
        step(1);
        chk("b2b_valid_k4", 32'(rd_valid), 32'd1);
        chk("b2b_data_k4", 32'(rd_data), 32'd2);
        step(1);
        do_read(4'd4, 1'b0, '0, 1'b0, d, e);
        chk("b2b_p4_not_cleared", 32'(d), 32'd2);

        // Global clear on capture edge returns pre-clear value
        do_read(4'd3, 1'b0, '0, 1'b1, d, e);
        chk("clrall_preclear", 32'(d), 32'd2);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("clrall_p3", 32'(d), 32'd0);
        do_read(4'd4, 1'b0, '0, 1'b0, d, e);
        chk("clrall_p4", 32'(d), 32'd0);

        // Reset during READ with port 2 held high
        pulse(2);
        trig[2] = 1'b1;
        step(2);
        rd_req  = 1'b1;
        rd_addr = 4'd2;
        step(1);
        rd_req = 1'b0;
        chk("rstrd_in_read", 32'(busy), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstrd_no_valid", 32'(rd_valid), 32'd0);
            step(1);
        end
        chk("rstrd_idle", 32'(busy), 32'd0);
        do_read(4'd2, 1'b0, '0, 1'b0, d, e);
        chk("rstrd_p2_zero", 32'(d), 32'd0);
        trig[2] = 1'b0;
        step(1);
        trig[2] = 1'b1;
        step(1);
        trig[2] = 1'b0;
        do_read(4'd2, 1'b0, '0, 1'b0, d, e);
        chk("rstrd_p2_new_edge", 32'(d), 32'd1);
        do_read(4'd3, 1'b0, '0, 1'b0, d, e);
        chk("rstrd_p3_zero", 32'(d), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
